pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
Parametrised program-counter unit for the single-cycle RV32I core, and the next generation of the current PC register.
- Holds the fetch PC and computes next-PC from four sources: sequential, branch (PC+imm), JALR ((base+imm)&~1) and trap/return.
- Adds a fetch valid/ready handshake, a saved exception PC (EPC), and misaligned-target detection.
- Sits between the control/immediate units and instruction memory.

Parameters:
XLEN, 32, width of PC, immediate, base and EPC.
RESET_VEC, 32'h0000_0000, PC value loaded by reset.
TRAP_VEC, 32'h0000_0100, PC loaded on trap entry or misaligned target.
STEP, 4, sequential increment.
ALIGN_BITS, 2, number of low target bits that must be zero (2 = IALIGN32, 1 = compressed-capable).

Ports:
clk  in  1  system clock, rising edge.
arst  in  1  synchronous active-low reset.
load  in  1  advance enable for sequential/branch/JALR updates.
pc_src  in  2  00 sequential, 01 branch, 10 JALR, 11 reserved (treated as sequential).
imm_ext  in  XLEN  sign-extended immediate.
jalr_base  in  XLEN  rs1 value for JALR.
trap_req  in  1  synchronous trap request.
mret  in  1  return from trap.
fetch_ready  in  1  instruction memory accepts the current PC.
fetch_valid  out  1  current PC is valid for fetch.
pc  out  XLEN  current fetch PC.
pc_plus_step  out  XLEN  pc+STEP, combinational, used for JAL/JALR link.
epc  out  XLEN  saved exception PC.
misalign_trap  out  1  one-cycle registered pulse on misaligned target.
misalign_addr  out  XLEN  offending target, captured with the pulse.

Behaviour:
- Reset: synchronous active-low on arst.
  - While arst=0 at a rising edge: pc=RESET_VEC, epc=0, misalign_trap=0, misalign_addr=0, fetch_valid=0, state=HOLD.
  - Reset asserted mid-operation discards any pending redirect.
- State machine:
  - HOLD: fetch_valid=0. Next state is RUN. This gives a one-cycle bubble after reset release.
  - RUN: fetch_valid=1.
  - BUBBLE: fetch_valid=0. Entered after any redirect (trap, mret, misaligned). Next state is RUN.
- Accept: accept = fetch_valid & fetch_ready & load.
- Priority at each rising edge in RUN or BUBBLE (first match wins):
  1. trap_req=1: epc<=pc, pc<=TRAP_VEC, go to BUBBLE. Ignores load and fetch_ready.
  2. mret=1: pc<=epc, epc unchanged, go to BUBBLE. Ignores load and fetch_ready.
  3. accept=1 and pc_src=01/10 and target[ALIGN_BITS-1:0]!=0:
     - epc<=pc, pc<=TRAP_VEC.
     - misalign_trap<=1, misalign_addr<=target.
     - Go to BUBBLE.
  4. accept=1: pc<=target (sequential pc+STEP, branch pc+imm_ext, JALR (jalr_base+imm_ext) with bit0 cleared).
  5. Otherwise: pc holds.
- In HOLD, trap_req and mret are ignored.
- misalign_trap is high for exactly one cycle, then returns to 0. misalign_addr holds until the next misaligned event or reset.
- Arithmetic: all adds are XLEN-bit modulo 2^XLEN. 0xFFFF_FFFC+4 wraps to 0 with no flag. Negative immediates are two's complement.
- JALR bit0 is cleared before the alignment check. With ALIGN_BITS=2, (base+imm)=0x103 becomes 0x102 and traps.
- Stall: load=0 or fetch_ready=0 freezes pc, epc and the state (RUN stays RUN).
- pc_plus_step is combinational from the pc register and is valid in all states.

Decomposition:
- Package pc_pkg holds:
  - pc_src encodings: PC_SEQ, PC_BR, PC_JALR, PC_RSVD.
  - State encodings: HOLD, RUN, BUBBLE.
  - Default RESET_VEC and TRAP_VEC constants.
- One sub-module, pc_target_calc (combinational):
  - Inputs: pc, pc_src, imm_ext, jalr_base.
  - Outputs: target and misaligned flag, parametrised by XLEN, STEP, ALIGN_BITS.
- pc_unit holds the registers, state machine and priority logic.

Test Plan:
- Reset with arst=0 for 2 cycles, then release with load=1, fetch_ready=1, pc_src=00 -> pc=0 with fetch_valid=0 on the first cycle; then fetch_valid=1 and pc sequence 0,4,8,12.
- At pc=0x20, pc_src=01, imm_ext=0xFFFF_FFF0 -> next pc=0x10. Then pc_src=10, jalr_base=0x201, imm_ext=0x3 -> pc=0x204.
- At pc=0x40, pc_src=01, imm_ext=0x6 -> misalign_trap=1 for one cycle, misalign_addr=0x46, epc=0x40, pc=0x100, one fetch_valid=0 bubble.
- At pc=0x80, trap_req=1 and mret=1 together with fetch_ready=0 -> trap wins: epc=0x80, pc=0x100, bubble. Later mret=1 -> pc=0x80.
- Stall: hold fetch_ready=0 for 3 cycles at pc=0x30 -> pc stays 0x30, fetch_valid stays 1. Then load=0 for 2 cycles -> pc unchanged.
- Wrap and reset: at pc=0xFFFF_FFFC with a sequential step -> pc=0. Assert arst=0 mid-stream during BUBBLE -> pc=RESET_VEC, epc=0, misalign_trap=0 on that edge.

Source files
------------

// File: rtl/pc_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pc_pkg
// Purpose : Shared encodings and default vectors for the program-counter unit.
//           - pc_src_e   : next-PC source selection
//           - pc_state_e : fetch-control state machine states
//           - DEF_*_VEC  : default reset and trap vectors
// Revision: 1.0 - initial release
// ============================================================================
package pc_pkg;

  typedef enum logic [1:0] {
    PC_SEQ  = 2'b00,
    PC_BR   = 2'b01,
    PC_JALR = 2'b10,
    PC_RSVD = 2'b11
  } pc_src_e;

  typedef enum logic [1:0] {
    HOLD   = 2'b00,
    RUN    = 2'b01,
    BUBBLE = 2'b10
  } pc_state_e;

  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VEC  = 32'h0000_0100;

endpackage : pc_pkg
`default_nettype wire

// File: rtl/pc_target_calc.sv
`default_nettype none
// ============================================================================
// Module  : pc_target_calc
// Purpose : Combinational next-PC target generator with alignment check.
// Ports   :
//   pc         in  XLEN  current fetch PC
//   pc_src     in  2     source select (seq / branch / JALR / reserved=seq)
//   imm_ext    in  XLEN  sign-extended immediate
//   jalr_base  in  XLEN  rs1 value for JALR
//   target     out XLEN  candidate next PC
//   misaligned out 1     redirect target violates ALIGN_BITS alignment
// Revision: 1.0 - initial release
// ============================================================================
module pc_target_calc
  import pc_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int STEP       = 4,
  parameter int ALIGN_BITS = 2
) (
  input  logic [XLEN-1:0] pc,
  input  logic [1:0]      pc_src,
  input  logic [XLEN-1:0] imm_ext,
  input  logic [XLEN-1:0] jalr_base,
  output logic [XLEN-1:0] target,
  output logic            misaligned
);

  localparam logic [XLEN-1:0] STEP_W = XLEN'(STEP);

  logic [XLEN-1:0] jalr_sum;
  logic            is_redirect;

  assign jalr_sum = jalr_base + imm_ext;

  always_comb begin
    target      = pc + STEP_W;
    is_redirect = 1'b0;
    case (pc_src)
      PC_BR: begin
        target      = pc + imm_ext;
        is_redirect = 1'b1;
      end
      PC_JALR: begin
        // bit0 is forced low before the alignment check, so with two
        // alignment bits an odd sum still traps on bit1 when set.
        target      = {jalr_sum[XLEN-1:1], 1'b0};
        is_redirect = 1'b1;
      end
      default: begin
        target      = pc + STEP_W;
        is_redirect = 1'b0;
      end
    endcase
  end

  // Sequential steps are never checked: STEP is assumed to preserve alignment.
  generate
    if (ALIGN_BITS > 0) begin : g_align_chk
      assign misaligned = is_redirect & (|target[ALIGN_BITS-1:0]);
    end else begin : g_align_none
      assign misaligned = 1'b0;
    end
  endgenerate

endmodule : pc_target_calc
`default_nettype wire

// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
// Module  : pc_unit
// Purpose : Program-counter unit for the single-cycle RV32I core. Holds the
//           fetch PC, selects the next PC, handles trap entry / mret return,
//           saves EPC and raises a one-cycle pulse on misaligned targets.
// Ports   :
//   clk           in  1     system clock, rising edge
//   arst          in  1     synchronous active-low reset
//   load          in  1     advance enable for seq/branch/JALR updates
//   pc_src        in  2     00 seq, 01 branch, 10 JALR, 11 treated as seq
//   imm_ext       in  XLEN  sign-extended immediate
//   jalr_base     in  XLEN  rs1 value for JALR
//   trap_req      in  1     synchronous trap request
//   mret          in  1     return from trap
//   fetch_ready   in  1     instruction memory accepts current PC
//   fetch_valid   out 1     current PC is valid for fetch
//   pc            out XLEN  current fetch PC
//   pc_plus_step  out XLEN  pc + STEP (link value)
//   epc           out XLEN  saved exception PC
//   misalign_trap out 1     one-cycle pulse on misaligned target
//   misalign_addr out XLEN  offending target, captured with the pulse
// Revision: 1.0 - initial release
// ============================================================================
module pc_unit
  import pc_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_VEC  = XLEN'(DEF_RESET_VEC),
  parameter logic [XLEN-1:0] TRAP_VEC   = XLEN'(DEF_TRAP_VEC),
  parameter int              STEP       = 4,
  parameter int              ALIGN_BITS = 2
) (
  input  logic            clk,
  input  logic            arst,
  input  logic            load,
  input  logic [1:0]      pc_src,
  input  logic [XLEN-1:0] imm_ext,
  input  logic [XLEN-1:0] jalr_base,
  input  logic            trap_req,
  input  logic            mret,
  input  logic            fetch_ready,
  output logic            fetch_valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus_step,
  output logic [XLEN-1:0] epc,
  output logic            misalign_trap,
  output logic [XLEN-1:0] misalign_addr
);

  localparam logic [XLEN-1:0] STEP_W = XLEN'(STEP);

  pc_state_e       state, state_nxt;
  logic [XLEN-1:0] pc_nxt, epc_nxt, misalign_addr_nxt;
  logic            misalign_trap_nxt;
  logic [XLEN-1:0] target;
  logic            misaligned;
  logic            accept;

  pc_target_calc #(
    .XLEN       (XLEN),
    .STEP       (STEP),
    .ALIGN_BITS (ALIGN_BITS)
  ) u_target_calc (
    .pc         (pc),
    .pc_src     (pc_src),
    .imm_ext    (imm_ext),
    .jalr_base  (jalr_base),
    .target     (target),
    .misaligned (misaligned)
  );

  assign fetch_valid  = (state == RUN);
  assign pc_plus_step = pc + STEP_W;
  // fetch_valid is low outside RUN, so no sequential update can happen there.
  assign accept       = fetch_valid & fetch_ready & load;

  always_ff @(posedge clk) begin
    if (!arst) begin
      state         <= HOLD;
      pc            <= RESET_VEC;
      epc           <= '0;
      misalign_trap <= 1'b0;
      misalign_addr <= '0;
    end else begin
      state         <= state_nxt;
      pc            <= pc_nxt;
      epc           <= epc_nxt;
      misalign_trap <= misalign_trap_nxt;
      misalign_addr <= misalign_addr_nxt;
    end
  end

  always_comb begin
    state_nxt         = state;
    pc_nxt            = pc;
    epc_nxt           = epc;
    misalign_trap_nxt = 1'b0;
    misalign_addr_nxt = misalign_addr;

    case (state)
      HOLD: begin
        // Redirect requests are ignored here; this is the post-reset bubble.
        state_nxt = RUN;
      end
      RUN, BUBBLE: begin
        if (state == BUBBLE) begin
          state_nxt = RUN;
        end
        if (trap_req) begin
          epc_nxt   = pc;
          pc_nxt    = TRAP_VEC;
          state_nxt = BUBBLE;
        end else if (mret) begin
          pc_nxt    = epc;
          state_nxt = BUBBLE;
        end else if (accept && misaligned) begin
          epc_nxt           = pc;
          pc_nxt            = TRAP_VEC;
          misalign_trap_nxt = 1'b1;
          misalign_addr_nxt = target;
          state_nxt         = BUBBLE;
        end else if (accept) begin
          pc_nxt = target;
        end
      end
      default: begin
        state_nxt = HOLD;
      end
    endcase
  end

endmodule : pc_unit
`default_nettype wire

// File: tb/tb_pc_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_pc_unit
// Purpose : Self-checking bench for pc_unit. Vectors hold the inputs applied
//           before a rising edge and the outputs expected after that edge.
// Revision: 1.0 - initial release
// ============================================================================
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        arst, load, trap_req, mret, fetch_ready;
  logic [1:0]  pc_src;
  logic [31:0] imm_ext, jalr_base;
  logic        fetch_valid, misalign_trap;
  logic [31:0] pc, pc_plus_step, epc, misalign_addr;

  always #5 clk = ~clk;

  pc_unit dut (
    .clk           (clk),
    .arst          (arst),
    .load          (load),
    .pc_src        (pc_src),
    .imm_ext       (imm_ext),
    .jalr_base     (jalr_base),
    .trap_req      (trap_req),
    .mret          (mret),
    .fetch_ready   (fetch_ready),
    .fetch_valid   (fetch_valid),
    .pc            (pc),
    .pc_plus_step  (pc_plus_step),
    .epc           (epc),
    .misalign_trap (misalign_trap),
    .misalign_addr (misalign_addr)
  );

  typedef struct {
    logic        arst, load;
    logic [1:0]  src;
    logic [31:0] imm, base;
    logic        trap, mret, rdy;
    logic [31:0] pc;
    logic        fv;
    logic [31:0] epc;
    logic        mt;
    logic [31:0] ma;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic        fv;
    logic [31:0] epc;
    logic        mt;
    logic [31:0] ma;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;

  function automatic vec_t mk(input logic a, input logic ld, input logic [1:0] s,
                              input logic [31:0] im, input logic [31:0] b,
                              input logic t, input logic m, input logic r,
                              input logic [31:0] epc_pc, input logic efv,
                              input logic [31:0] eepc, input logic emt,
                              input logic [31:0] ema);
    vec_t v;
    v.arst = a;  v.load = ld; v.src = s;  v.imm = im; v.base = b;
    v.trap = t;  v.mret = m;  v.rdy = r;
    v.pc = epc_pc; v.fv = efv; v.epc = eepc; v.mt = emt; v.ma = ema;
    return v;
  endfunction

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s step %0d: got %h expected %h", name, idx, act, req);
  endtask

  task automatic apply(input vec_t v, input int idx);
    exp_t e;
    arst = v.arst; load = v.load; pc_src = v.src; imm_ext = v.imm;
    jalr_base = v.base; trap_req = v.trap; mret = v.mret; fetch_ready = v.rdy;
    sb.push_back('{pc: v.pc, fv: v.fv, epc: v.epc, mt: v.mt, ma: v.ma});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("pc",            idx, pc,                   e.pc);
    check("fetch_valid",   idx, {31'd0, fetch_valid}, {31'd0, e.fv});
    check("epc",           idx, epc,                  e.epc);
    check("misalign_trap", idx, {31'd0, misalign_trap}, {31'd0, e.mt});
    check("misalign_addr", idx, misalign_addr,        e.ma);
    check("pc_plus_step",  idx, pc_plus_step,         e.pc + 32'd4);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset, release, sequential run up to 0x20.
    vecs.push_back(mk(0,1,2'b00,0,0,0,0,1, 32'h0,0,0,0,0));
    vecs.push_back(mk(0,1,2'b00,0,0,0,0,1, 32'h0,0,0,0,0));
    vecs.push_back(mk(1,1,2'b00,0,0,0,0,1, 32'h0,1,0,0,0));
    for (int a = 4; a <= 32'h20; a += 4)
      vecs.push_back(mk(1,1,2'b00,0,0,0,0,1, a,1,0,0,0));
    // Backward branch, JALR, branch to 0x40.
    vecs.push_back(mk(1,1,2'b01,32'hFFFF_FFF0,0,0,0,1, 32'h10,1,0,0,0));
    vecs.push_back(mk(1,1,2'b10,32'h3,32'h201,0,0,1,   32'h204,1,0,0,0));
    vecs.push_back(mk(1,1,2'b01,32'hFFFF_FE3C,0,0,0,1, 32'h40,1,0,0,0));
    // Misaligned branch target 0x46, then bubble, then pulse clears.
    vecs.push_back(mk(1,1,2'b01,32'h6,0,0,0,1,  32'h100,0,32'h40,1,32'h46));
    vecs.push_back(mk(1,1,2'b00,0,0,0,0,1,      32'h100,1,32'h40,0,32'h46));
    vecs.push_back(mk(1,1,2'b01,32'hFFFF_FF80,0,0,0,1, 32'h80,1,32'h40,0,32'h46));
    // Trap and mret together with fetch_ready low: trap wins.
    vecs.push_back(mk(1,1,2'b00,0,0,1,1,0,      32'h100,0,32'h80,0,32'h46));
    vecs.push_back(mk(1,1,2'b00,0,0,0,0,1,      32'h100,1,32'h80,0,32'h46));
    vecs.push_back(mk(1,1,2'b00,0,0,0,1,1,      32'h80,0,32'h80,0,32'h46));
    vecs.push_back(mk(1,0,2'b00,0,0,0,0,1,      32'h80,1,32'h80,0,32'h46));
    // JALR to 0x30, then stalls on fetch_ready and on load.
    vecs.push_back(mk(1,1,2'b10,0,32'h30,0,0,1, 32'h30,1,32'h80,0,32'h46));
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(1,1,2'b00,0,0,0,0,0,    32'h30,1,32'h80,0,32'h46));
    for (int k = 0; k < 2; k++)
      vecs.push_back(mk(1,0,2'b00,0,0,0,0,1,    32'h30,1,32'h80,0,32'h46));
    vecs.push_back(mk(1,1,2'b11,0,0,0,0,1,      32'h34,1,32'h80,0,32'h46));
    // Wrap at the top of the address space.
    vecs.push_back(mk(1,1,2'b10,32'hC,32'hFFFF_FFF0,0,0,1, 32'hFFFF_FFFC,1,32'h80,0,32'h46));
    vecs.push_back(mk(1,1,2'b00,0,0,0,0,1,      32'h0,1,32'h80,0,32'h46));
    vecs.push_back(mk(1,1,2'b00,0,0,0,0,1,      32'h4,1,32'h80,0,32'h46));
    // JALR 0x103 -> 0x102 still misaligned on bit1.
    vecs.push_back(mk(1,1,2'b10,32'h3,32'h100,0,0,1, 32'h100,0,32'h4,1,32'h102));
    // Reset during BUBBLE with a pending trap request: everything cleared.
    vecs.push_back(mk(0,1,2'b00,0,0,1,0,1,      32'h0,0,32'h0,0,32'h0));
    // Trap in HOLD is ignored.
    vecs.push_back(mk(1,1,2'b00,0,0,1,0,1,      32'h0,1,32'h0,0,32'h0));
    vecs.push_back(mk(1,1,2'b00,0,0,0,0,1,      32'h4,1,32'h0,0,32'h0));

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Back-to-back traps: the second is taken in BUBBLE and saves TRAP_VEC.
    apply(mk(1,1,2'b00,0,0,1,0,1, 32'h100,0,32'h4,0,0),   100);
    apply(mk(1,1,2'b00,0,0,1,0,0, 32'h100,0,32'h100,0,0), 101);
    apply(mk(1,1,2'b00,0,0,0,0,1, 32'h100,1,32'h100,0,0), 102);
    apply(mk(1,1,2'b00,0,0,0,0,1, 32'h104,1,32'h100,0,0), 103);

    if (sb.size() != 0) begin
      n_total++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_pc_unit
`default_nettype wire
